// File: rtl/fp_add_sub_lanes.sv
// fp_add_sub_lanes: LANES x FP32 add/sub behind valid/ready, credit-gated.
// Ports: clock, reset_n (async, active-low), in_valid/in_ready,
//   in_a/in_b (lane i at [32i+:32]), in_op (1 = a-b), in_mask, in_tag,
//   out_valid/out_ready, out_q, out_mask, out_tag.
// Build option FP_ADDSUB_PERF_EN adds perf_ops / perf_stall counters.

module fp_add_sub_core #(
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] q
);

  function automatic logic [31:0] fadd(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        sub
  );
    logic [31:0] big, sml;
    logic        sy, eff_sub, ru;
    logic        x_nan, y_nan, x_inf, y_inf;
    logic [9:0]  eb, es, e, d;
    logic [23:0] mb, ms;
    logic [49:0] wide;
    logic [26:0] ab, as_, n;
    logic [27:0] s;
    logic [24:0] m;
    int          p, lz;
    sy    = y[31] ^ sub;
    x_nan = (&x[30:23]) && (|x[22:0]);
    y_nan = (&y[30:23]) && (|y[22:0]);
    x_inf = (&x[30:23]) && !(|x[22:0]);
    y_inf = (&y[30:23]) && !(|y[22:0]);
    if (x_nan || y_nan || (x_inf && y_inf && x[31] != sy))
      return 32'h7fc0_0000;
    if (x_inf) return x;
    if (y_inf) return {sy, y[30:0]};
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = {sy, y[30:0]};
    end else begin
      big = {sy, y[30:0]};
      sml = x;
    end
    eff_sub = big[31] ^ sml[31];
    // subnormals use exponent 1 with a zero hidden bit
    eb = (big[30:23] == 8'd0) ? 10'd1 : {2'b0, big[30:23]};
    es = (sml[30:23] == 8'd0) ? 10'd1 : {2'b0, sml[30:23]};
    mb = {|big[30:23], big[22:0]};
    ms = {|sml[30:23], sml[22:0]};
    d  = eb - es;
    // 3 extra bits: guard, round, sticky
    wide = {ms, 26'd0} >> d;
    as_  = (d >= 10'd26) ? {26'd0, |ms}
                         : {wide[49:24], |wide[23:0]};
    ab   = {mb, 3'd0};
    s    = eff_sub ? ({1'b0, ab} - {1'b0, as_})
                   : ({1'b0, ab} + {1'b0, as_});
    if (s == 28'd0) return {big[31] & ~eff_sub, 31'd0};
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = eb + 10'd1;
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++)
        if (s[i]) p = i;
      lz = 26 - p;
      // stop normalising at the subnormal boundary
      if (lz > int'(eb) - 1) lz = int'(eb) - 1;
      n = s[26:0] << lz;
      e = eb - 10'(lz);
    end
    if (!n[26]) e = 10'd0;
    ru = n[2] & (n[1] | n[0] | n[3]);
    m  = {1'b0, n[26:3]} + 25'(ru);
    if (m[24]) begin
      e = e + 10'd1;
      m = m >> 1;
    end else if (e == 10'd0 && m[23]) begin
      e = 10'd1;
    end
    if (e >= 10'd255) return {big[31], 8'hff, 23'd0};
    return {big[31], e[7:0], m[22:0]};
  endfunction

  logic [31:0] pipe [LATENCY];

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fadd(a, b, op);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[LATENCY-1];

endmodule

module fp_add_sub_lanes #(
  parameter int LANES      = 4,
  parameter int LATENCY    = 3,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = LATENCY + 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*LANES-1:0]    in_a,
  input  logic [32*LANES-1:0]    in_b,
  input  logic [LANES-1:0]       in_op,
  input  logic [LANES-1:0]       in_mask,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*LANES-1:0]    out_q,
  output logic [LANES-1:0]       out_mask,
`ifdef FP_ADDSUB_PERF_EN
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall,
`endif
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int EW = 32*LANES + LANES + TAG_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 run, accept, pop, wr;
  logic [CW-1:0]        credits, cnt;
  logic [PW-1:0]        wp, rp;
  logic [LATENCY-1:0]   vld;
  logic [LANES-1:0]     mask_p [LATENCY];
  logic [TAG_WIDTH-1:0] tag_p  [LATENCY];
  logic [32*LANES-1:0]  res, res_m;
  logic [EW-1:0]        mem    [FIFO_DEPTH];

  assign in_ready  = run && (credits != '0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = vld[LATENCY-1];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_add_sub_core #(.LATENCY(LATENCY)) u_core (
      .clock  (clock),
      .areset (~reset_n),
      .a      (in_a[32*g +: 32]),
      .b      (in_b[32*g +: 32]),
      .op     (in_op[g]),
      .q      (res[32*g +: 32])
    );
    assign res_m[32*g +: 32] =
      mask_p[LATENCY-1][g] ? res[32*g +: 32] : 32'h0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      credits <= CW'(FIFO_DEPTH);
      vld     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        mask_p[i] <= '0;
        tag_p[i]  <= '0;
      end
    end else begin
      run    <= 1'b1;
      vld[0] <= accept;
      mask_p[0] <= in_mask;
      tag_p[0]  <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]    <= vld[i-1];
        mask_p[i] <= mask_p[i-1];
        tag_p[i]  <= tag_p[i-1];
      end
      if (accept && !pop)      credits <= credits - 1'b1;
      else if (pop && !accept) credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= {res_m, mask_p[LATENCY-1], tag_p[LATENCY-1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)
        wp <= (wp == PW'(FIFO_DEPTH-1)) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == PW'(FIFO_DEPTH-1)) ? '0 : rp + 1'b1;
      if (wr && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !wr) cnt <= cnt - 1'b1;
    end
  end

  assign {out_q, out_mask, out_tag} = out_valid ? mem[rp] : '0;

  a_credit_max: assert property (@(posedge clock) disable iff (!reset_n)
    credits <= CW'(FIFO_DEPTH));
  a_credit_min: assert property (@(posedge clock) disable iff (!reset_n)
    !(accept && credits == '0));
  a_no_ovf: assert property (@(posedge clock) disable iff (!reset_n)
    !(wr && cnt == CW'(FIFO_DEPTH)));

`ifdef FP_ADDSUB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept)                  perf_ops   <= perf_ops + 1'b1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_sub_lanes.sv
// Bench for fp_add_sub_lanes: random + directed beats checked against
// a real-arithmetic FP32 model and an expected-beat queue.

module tb_fp_add_sub_lanes;

  localparam int LANES = 4;
  localparam int LAT   = 3;
  localparam int TW    = 8;
  localparam int DEPTH = LAT + 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [32*LANES-1:0] in_a, in_b, out_q;
  logic [LANES-1:0] in_op, in_mask, out_mask;
  logic [TW-1:0]    in_tag, out_tag;
  logic             out_valid, out_ready;
`ifdef FP_ADDSUB_PERF_EN
  logic [31:0]      perf_ops, perf_stall;
`endif

  fp_add_sub_lanes #(
    .LANES(LANES), .LATENCY(LAT), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_mask(out_mask),
`ifdef FP_ADDSUB_PERF_EN
    .perf_ops(perf_ops), .perf_stall(perf_stall),
`endif
    .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [32*LANES-1:0] q;
    logic [LANES-1:0]    mask;
    logic [TW-1:0]       tag;
  } beat_t;

  beat_t expq[$];
  int n_chk, n_pass, npop;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // exact float -> double for normal values and zero
  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return f[31] ? -0.0 : 0.0;
    return $bitstoreal({f[31], 11'({3'b0, f[30:23]} + 11'd896),
                        f[22:0], 29'd0});
  endfunction

  // double -> float, round to nearest even (normal range only)
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    logic        ru;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e   = int'(d[62:52]) - 896;
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    ru  = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && m[0]);
    m   = m + 25'(ru);
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [32*LANES-1:0] model(
    input logic [32*LANES-1:0] a, input logic [32*LANES-1:0] b,
    input logic [LANES-1:0] op, input logic [LANES-1:0] mask);
    logic [32*LANES-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (mask[i])
        r[32*i +: 32] = op[i]
          ? r2f(f2r(a[32*i +: 32]) - f2r(b[32*i +: 32]))
          : r2f(f2r(a[32*i +: 32]) + f2r(b[32*i +: 32]));
    return r;
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] v;
    v[31]    = 1'($urandom % 2);
    v[30:23] = 8'(100 + $urandom % 55);
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  task automatic rnd_beat(input logic [TW-1:0] tag);
    logic [31:0] a, b;
    int c;
    for (int i = 0; i < LANES; i++) begin
      a = rnd_f();
      c = int'($urandom % 8);
      b = (c == 0) ? a : (c == 1) ? {~a[31], a[30:0]} : rnd_f();
      in_a[32*i +: 32] = a;
      in_b[32*i +: 32] = b;
    end
    in_op   = LANES'($urandom);
    in_mask = LANES'($urandom);
    in_tag  = tag;
  endtask

  // scoreboard / protocol monitor
  logic               stalled;
  logic [159:0]       held;
  beat_t              nb;
  initial begin
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_in_ready", 160'(in_ready), 160'(0));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        expq.delete();
        stalled = 1'b0;
      end else begin
        if (out_valid) begin
          if (expq.size() == 0) begin
            chk("stale_beat", 160'(out_valid), 160'(0));
          end else begin
            chk("out_q", 160'(out_q), 160'(expq[0].q));
            chk("out_mask", 160'(out_mask), 160'(expq[0].mask));
            chk("out_tag", 160'(out_tag), 160'(expq[0].tag));
          end
          if (stalled)
            chk("stall_stable", 160'({out_q, out_mask, out_tag}), held);
          held    = 160'({out_q, out_mask, out_tag});
          stalled = !out_ready;
          if (out_ready && expq.size() != 0) begin
            void'(expq.pop_front());
            npop++;
          end
        end else begin
          chk("idle_zero", 160'({out_q, out_mask, out_tag}), 160'(0));
          if (stalled) chk("stall_dropped", 160'(out_valid), 160'(1));
          stalled = 1'b0;
        end
        if (in_valid && in_ready) begin
          nb.q    = model(in_a, in_b, in_op, in_mask);
          nb.mask = in_mask;
          nb.tag  = in_tag;
          expq.push_back(nb);
        end
      end
    end
  end

  task automatic send();
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("send_accept", 160'(acc), 160'(1));
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    chk("wait_out", 160'(out_valid), 160'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (expq.size() == 0 && !out_valid) break;
    end
    chk("drain", 160'(expq.size()), 160'(0));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, nacc, lows, p0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_mask = '0; in_tag = '0;
    out_ready = 1'b1;

    chk("model_add", 160'(r2f(f2r(32'h3f80_0000) + f2r(32'h4000_0000))),
        160'(32'h4040_0000));
    chk("model_sub", 160'(r2f(f2r(32'h4040_0000) - f2r(32'h3f80_0000))),
        160'(32'h4000_0000));
    chk("model_cancel", 160'(r2f(f2r(32'hc2c8_0000) - f2r(32'hc2c8_0000))),
        160'(32'h0));

    repeat (2) @(negedge clock);
    chk("rst_out_q", 160'(out_q), 160'(0));
    #2 reset_n = 1'b1;
    chk("ready_before_edge", 160'(in_ready), 160'(0));
    @(posedge clock);
    #1;
    chk("ready_after_edge", 160'(in_ready), 160'(1));

    // basic latency
    in_a = {LANES{32'h3f80_0000}};
    in_b = {LANES{32'h4000_0000}};
    in_op = '0; in_mask = '1; in_tag = 8'h5a;
    t0 = cyc;
    send();
    wait_out();
    chk("latency", 160'(cyc - t0), 160'(LAT + 1));
    chk("basic_q", 160'(out_q), 160'({LANES{32'h4040_0000}}));
    chk("basic_tag", 160'(out_tag), 160'(8'h5a));
    drain();

    // sub + mask
    in_a = {LANES{32'h4040_0000}};
    in_b = {LANES{32'h3f80_0000}};
    in_op = 4'b1010; in_mask = 4'b0110; in_tag = 8'h11;
    send();
    wait_out();
    chk("submask_q", 160'(out_q),
        160'(128'h0000_0000_4080_0000_4000_0000_0000_0000));
    chk("submask_mask", 160'(out_mask), 160'(4'b0110));
    drain();

    // backpressure
    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      rnd_beat(TW'(nacc));
      in_valid = 1'b1;
      @(negedge clock);
      if (in_ready) nacc++;
      @(posedge clock);
      #1;
    end
    chk("bp_accepted", 160'(nacc), 160'(DEPTH));
    @(negedge clock);
    chk("bp_ready_low", 160'(in_ready), 160'(0));
    @(posedge clock);
    #1;
    p0 = npop;
    out_ready = 1'b1;
    for (int t = nacc; t < 10; t++) begin
      if (t != nacc) rnd_beat(TW'(t));
      send();
    end
    drain();
    chk("bp_pops", 160'(npop - p0), 160'(10));

    // full throughput
    lows = 0;
    p0 = npop;
    for (int i = 0; i < 100; i++) begin
      rnd_beat(TW'(i));
      in_valid = 1'b1;
      @(negedge clock);
      if (!in_ready) lows++;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("tp_ready_lows", 160'(lows), 160'(0));
    drain();
    chk("tp_pops", 160'(npop - p0), 160'(100));

    // reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      rnd_beat(TW'(8'hc0 + i));
      send();
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 160'(out_valid), 160'(0));
    chk("midrst_in_ready", 160'(in_ready), 160'(0));
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    chk("rel_ready_low", 160'(in_ready), 160'(0));
    @(posedge clock);
    #1;
    chk("rel_ready_high", 160'(in_ready), 160'(1));
    p0 = npop;
    repeat (12) @(negedge clock);
    chk("no_stale_pops", 160'(npop - p0), 160'(0));

`ifdef FP_ADDSUB_PERF_EN
    @(posedge clock);
    #1;
    for (int i = 0; i < 9; i++) begin
      rnd_beat(TW'(i));
      send();
    end
    drain();
    out_ready = 1'b0;
    rnd_beat(TW'(9));
    send();
    wait_out();
    repeat (4) @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain();
    chk("perf_ops", 160'(perf_ops), 160'(10));
    chk("perf_stall", 160'(perf_stall), 160'(4));
`endif

    // random traffic with random backpressure
    @(posedge clock);
    #1;
    for (int c = 0; c < 400; c++) begin
      logic acc;
      out_ready = ($urandom % 4) != 0;
      if (!in_valid && ($urandom % 3) != 0) begin
        rnd_beat(TW'($urandom));
        in_valid = 1'b1;
      end
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
